// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage registers.
//   - pipe_state_e : occupancy state of a stage (EMPTY / BUSY / FULL)
//   - <BOUNDARY>_CTRL_W / <BOUNDARY>_DATA_W : per-boundary bundle widths
//     for the IF/ID, ID/EX, EX/MEM and MEM/WB stage boundaries.
package pipe_pkg;

  // EMPTY: nothing held; BUSY: main register full; FULL: main and skid full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned IFID_CTRL_W  = 1;
  localparam int unsigned IFID_DATA_W  = 64;
  localparam int unsigned IDEX_CTRL_W  = 12;
  localparam int unsigned IDEX_DATA_W  = 133;
  localparam int unsigned EXMEM_CTRL_W = 5;
  localparam int unsigned EXMEM_DATA_W = 101;
  localparam int unsigned MEMWB_CTRL_W = 3;
  localparam int unsigned MEMWB_DATA_W = 101;

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: saturating event counter.
//   clk   - clock, counts on rising edge
//   rst   - asynchronous active-high reset, clears the count
//   inc_i - count enable for this cycle
//   cnt_o - current count, sticks at all-ones once reached
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with a two-entry
// (main + skid) buffer, valid/ready handshake on both sides and flush.
// Optional performance counters are built when PIPE_PERF_EN is defined.
//
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   flush             - drop every held entry at the next edge
//   in_valid/in_ready - upstream handshake (in_ready is a flop output)
//   in_ctrl/in_data   - upstream control bundle and payload
//   out_valid/out_ready - downstream handshake (out_valid is a flop output)
//   out_ctrl/out_data - main-register contents; out_ctrl is 0 when idle
//   stall_cnt         - cycles with out_valid=1, out_ready=0 (PIPE_PERF_EN)
//   bubble_cnt        - cycles with out_valid=0 (PIPE_PERF_EN)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = MEMWB_CTRL_W,
  parameter int unsigned DATA_W = MEMWB_DATA_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Reject degenerate configurations at elaboration.
  if ((CTRL_W < 1) || (DATA_W < 1) || (CNT_W < 1)) begin : g_bad_param
    $error("pipe_stage_reg: CTRL_W, DATA_W and CNT_W must be at least 1");
  end

  pipe_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic accept;
  logic fire;

  // Handshakes use only registered readiness/validity, so there is no
  // combinational path from out_ready to in_ready.
  assign accept = in_valid & in_ready_q;
  assign fire   = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Payload fields keep their contents; only control is scrubbed so a
      // flushed entry can never assert write-enables downstream.
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = BUSY;
          end
        end
        BUSY: begin
          if (fire && accept) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (fire) begin
            main_ctrl_d = '0;
            state_d     = EMPTY;
          end else if (accept) begin
            // Downstream stalled this cycle: park the new entry in skid.
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = FULL;
          end
        end
        FULL: begin
          if (fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
            state_d     = BUSY;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end

    // Handshake flags are registered copies of the next occupancy.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;

`ifdef PIPE_PERF_EN
  // Counters observe the registered outputs; a flush cycle with an empty
  // main register is therefore a bubble like any other idle cycle.
  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_valid_q & ~out_ready),
    .cnt_o (stall_cnt)
  );

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (~out_valid_q),
    .cnt_o (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized bench for pipe_stage_reg.
// The reference model treats the stage as a two-deep FIFO: in_ready means
// "fewer than two entries held", outputs show the oldest entry, and flush
// empties it. Build with +define+PIPE_PERF_EN to also cover the counters.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = MEMWB_CTRL_W;
  localparam int DW = MEMWB_DATA_W;
  localparam int NW = 4;
  localparam int SAT = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_PERF_EN
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] bubble_cnt;
`endif

  pipe_stage_reg #(
    .CTRL_W (CW),
    .DATA_W (DW),
    .CNT_W  (NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] dq[$];
  int            m_stall;
  int            m_bubble;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(mq.size() < 2));
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk({tag, ".out_ctrl"}, 128'(out_ctrl), 128'(mq[0].c));
      chk({tag, ".out_data"}, 128'(out_data), 128'(mq[0].d));
    end else begin
      chk({tag, ".out_ctrl_idle"}, 128'(out_ctrl), 128'(0));
    end
`ifdef PIPE_PERF_EN
    chk({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(m_stall));
    chk({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(m_bubble));
`endif
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // One clock edge with the currently driven inputs; model updated alongside.
  task automatic step();
    bit acc;
    bit fir;
    ent_t e;
    acc = in_valid && (mq.size() < 2);
    fir = (mq.size() > 0) && out_ready;
    if ((mq.size() > 0) && !out_ready && (m_stall < SAT)) m_stall++;
    if ((mq.size() == 0) && (m_bubble < SAT)) m_bubble++;
    if (out_valid && out_ready) dq.push_back(out_data);
    e.c = in_ctrl;
    e.d = in_data;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (fir) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    mq.delete();
    m_stall  = 0;
    m_bubble = 0;
    chk("arst.out_valid", 128'(out_valid), 128'(0));
    chk("arst.out_ctrl", 128'(out_ctrl), 128'(0));
    chk("arst.out_data", 128'(out_data), 128'(0));
    chk("arst.in_ready", 128'(in_ready), 128'(1));
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    m_stall  = 0;
    m_bubble = 0;
    #2;
    chk("reset.in_ready", 128'(in_ready), 128'(1));
    chk("reset.out_valid", 128'(out_valid), 128'(0));
    chk("reset.out_ctrl", 128'(out_ctrl), 128'(0));
    chk("reset.out_data", 128'(out_data), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Stream 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 3'b011, DW'(i), 1'b1, 1'b0);
      step();
      check_model("stream");
      chk("stream.data_seq", 128'(out_data), 128'(i));
      chk("stream.ready_hi", 128'(in_ready), 128'(1));
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check_model("stream_drain");

    // Backpressure.
    dq.delete();
    drive(1'b1, 3'b011, DW'(1), 1'b1, 1'b0);
    step();
    check_model("bp.load");
    drive(1'b1, 3'b011, DW'(2), 1'b0, 1'b0);
    step();
    check_model("bp.skid");
    chk("bp.ready_lo", 128'(in_ready), 128'(0));
    chk("bp.hold1", 128'(out_data), 128'(1));
    drive(1'b1, 3'b011, DW'(3), 1'b0, 1'b0);
    step();
    check_model("bp.stall");
    chk("bp.hold1b", 128'(out_data), 128'(1));
    drive(1'b1, 3'b011, DW'(3), 1'b1, 1'b0);
    step();
    check_model("bp.rel1");
    chk("bp.ready_back", 128'(in_ready), 128'(1));
    step();
    check_model("bp.rel2");
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check_model("bp.rel3");
    step();
    chk("bp.n_out", 128'(dq.size()), 128'(3));
    for (int i = 0; i < dq.size() && i < 3; i++) chk("bp.order", 128'(dq[i]), 128'(i + 1));

    // Flush while FULL.
    dq.delete();
    drive(1'b1, 3'b101, DW'(8'hA), 1'b0, 1'b0);
    step();
    drive(1'b1, 3'b110, DW'(8'hB), 1'b0, 1'b0);
    step();
    check_model("fl.full");
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    step();
    check_model("fl.after");
    chk("fl.out_valid", 128'(out_valid), 128'(0));
    chk("fl.out_ctrl", 128'(out_ctrl), 128'(0));
    chk("fl.in_ready", 128'(in_ready), 128'(1));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_model("fl.idle");
    end
    chk("fl.none_out", 128'(dq.size()), 128'(0));

    // Flush with a simultaneous accept.
    drive(1'b1, 3'b111, DW'(8'hC), 1'b1, 1'b1);
    step();
    check_model("flacc");
    chk("flacc.dropped", 128'(out_valid), 128'(0));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    check_model("flacc.idle");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, CW'($urandom), rnd_data(), ($urandom % 3) != 0,
            ($urandom % 20) == 0);
      step();
      check_model("rand");
    end

    // Asynchronous reset between edges.
    drive(1'b1, 3'b011, DW'(8'h21), 1'b0, 1'b0);
    step();
    drive(1'b1, 3'b011, DW'(8'h22), 1'b0, 1'b0);
    step();
    #2;
    async_reset();
    drive(1'b1, 3'b010, DW'(8'h55), 1'b0, 1'b0);
    step();
    check_model("arst.first");
    chk("arst.lat1_data", 128'(out_data), 128'(8'h55));
    chk("arst.lat1_valid", 128'(out_valid), 128'(1));

`ifdef PIPE_PERF_EN
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    async_reset();
    for (int i = 0; i < 5; i++) step();
    check_model("perf.idle");
    chk("perf.bubble5", 128'(bubble_cnt), 128'(5));
    drive(1'b1, 3'b001, DW'(8'h77), 1'b0, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check_model("perf.stall");
    chk("perf.stall_sat", 128'(stall_cnt), 128'(SAT));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
